// File: rtl/cuenta_pkg.sv
// cuenta_pkg: state encodings and defaults shared by the master and the counting unit.
package cuenta_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        ARRANQUE = 2'd1,
        ESPERA   = 2'd2,
        ENTREGA  = 2'd3
    } estado_t;

    localparam int TIMEOUT_DEF = 32;
    localparam int W_VALOR_DEF = 3;

endpackage

// File: rtl/temporizador.sv
// temporizador: saturating timeout counter with clear, enable and terminal-count output.
module temporizador
    import cuenta_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] cnt;

    assign terminal = cnt == W'(TIMEOUT - 1);

    // Holding at terminal count keeps the counter from wrapping.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !terminal)
            cnt <= cnt + 1'b1;

endmodule

// File: rtl/maestro_cuenta.sv
// maestro_cuenta: host-side master that launches the counting unit, waits for fin or
// timeout, and holds the result until the host acknowledges it.
module maestro_cuenta
    import cuenta_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int W_VALOR = W_VALOR_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pet,
    input  logic [W_VALOR-1:0] valor_in,
    output logic               listo,
    output logic [W_VALOR-1:0] valor,
    output logic               start,
    input  logic [3:0]         cuenta,
    input  logic               fin,
    output logic [3:0]         resultado,
    output logic               valido,
    output logic               error,
    input  logic               ack
);

    estado_t state;
    logic    terminal;

    temporizador #(.TIMEOUT(TIMEOUT)) u_temporizador (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == ARRANQUE),
        .enable  (state == ESPERA && !fin),
        .terminal(terminal)
    );

    // listo/start/valido are registered alongside the state so they never glitch.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state     <= REPOSO;
            valor     <= '0;
            resultado <= '0;
            error     <= 1'b0;
            listo     <= 1'b1;
            start     <= 1'b0;
            valido    <= 1'b0;
        end else begin
            case (state)
                REPOSO:
                    if (pet) begin
                        valor <= valor_in;
                        listo <= 1'b0;
                        start <= 1'b1;
                        state <= ARRANQUE;
                    end
                ARRANQUE: begin
                    start <= 1'b0;
                    state <= ESPERA;
                end
                ESPERA:
                    if (fin || terminal) begin
                        resultado <= fin ? cuenta : 4'd0;
                        error     <= !fin;
                        valido    <= 1'b1;
                        state     <= ENTREGA;
                    end
                ENTREGA:
                    if (ack) begin
                        valido <= 1'b0;
                        listo  <= 1'b1;
                        state  <= REPOSO;
                    end
                default: state <= REPOSO;
            endcase
        end

endmodule

// File: tb/tb_maestro_cuenta.sv
// tb_maestro_cuenta: randomized bench comparing maestro_cuenta against a transaction-level outcome model.
module tb_maestro_cuenta;

    localparam int TO = 12;
    localparam int W  = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         pet = 1'b0;
    logic [W-1:0] valor_in = '0;
    logic         listo;
    logic [W-1:0] valor;
    logic         start;
    logic [3:0]   cuenta = '0;
    logic         fin = 1'b0;
    logic [3:0]   resultado;
    logic         valido;
    logic         error;
    logic         ack = 1'b0;

    int checks = 0;
    int failures = 0;
    int starts = 0;

    maestro_cuenta #(.TIMEOUT(TO), .W_VALOR(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pet      (pet),
        .valor_in (valor_in),
        .listo    (listo),
        .valor    (valor),
        .start    (start),
        .cuenta   (cuenta),
        .fin      (fin),
        .resultado(resultado),
        .valido   (valido),
        .error    (error),
        .ack      (ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (start === 1'b1) starts++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_listo"}, listo, 1);
        check({tag, "_start"}, start, 0);
        check({tag, "_valido"}, valido, 0);
        check({tag, "_valor"}, valor, 0);
        check({tag, "_resultado"}, resultado, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // One transaction: fin is raised in ESPERA cycle k (k >= TO means never).
    // Expected outcome: fin within the TO-cycle window wins, otherwise timeout.
    task automatic run_op(input logic [W-1:0] v, input int k, input logic [3:0] c,
                          input int hold, input bit stale);
        int          s0;
        bit          done;
        logic [3:0]  exp_res;
        logic        exp_err;
        s0      = starts;
        exp_err = (k >= TO);
        exp_res = exp_err ? 4'd0 : c;
        @(negedge clk);
        check("listo_idle", listo, 1);
        pet = 1'b1;
        valor_in = v;
        @(posedge clk); #1;
        check("start_pulse", start, 1);
        check("valor_load", valor, v);
        check("listo_busy", listo, 0);
        @(negedge clk);
        pet = $urandom;
        valor_in = W'($urandom);
        fin = stale;
        cuenta = 4'($urandom);
        ack = $urandom;
        @(posedge clk); #1;
        check("start_single", start, 0);
        check("valido_arranque", valido, 0);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            fin = (i == k);
            cuenta = (i == k) ? c : 4'($urandom);
            pet = $urandom;
            ack = $urandom;
            @(posedge clk); #1;
            done = (i == k) || (i == TO - 1);
            check("valido_wait", valido, done);
            if (done) break;
        end
        check("resultado", resultado, exp_res);
        check("error", error, exp_err);
        for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            fin = $urandom;
            ack = 1'b0;
            pet = $urandom;
            cuenta = 4'($urandom);
            @(posedge clk); #1;
            check("valido_hold", valido, 1);
            check("resultado_hold", resultado, exp_res);
            check("error_hold", error, exp_err);
            check("valor_hold", valor, v);
        end
        @(negedge clk);
        fin = 1'b0;
        ack = 1'b1;
        pet = $urandom;
        @(posedge clk); #1;
        check("valido_ack", valido, 0);
        check("listo_ack", listo, 1);
        check("no_start_ack", start, 0);
        @(negedge clk);
        ack = 1'b0;
        pet = 1'b0;
        check("start_count", starts - s0, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        run_op(3'b111, 4, 4'b0011, 0, 0);
        run_op(3'b101, TO + 5, 4'b1111, 1, 0);
        run_op(3'b001, TO - 1, 4'b1010, 0, 0);
        run_op(3'b110, 2, 4'b0110, 10, 0);
        run_op(3'b011, 0, 4'b1001, 0, 1);
        run_op(3'b100, 3, 4'b0101, 2, 1);

        @(negedge clk);
        pet = 1'b1;
        valor_in = 3'b101;
        @(negedge clk);
        pet = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_reset_outputs("reset_release");
        run_op(3'b010, 4, 4'b1100, 2, 0);

        for (int n = 0; n < 20; n++)
            run_op(W'($urandom), int'($urandom_range(0, TO + 3)), 4'($urandom),
                   int'($urandom_range(0, 5)), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maestro_cuenta.md
MAESTRO_CUENTA -- requirements
Module: maestro_cuenta

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter TIMEOUT SHALL default to 32 and set the maximum ESPERA cycles before abort (legal range 2..255).
REQ-003 Parameter W_VALOR SHALL default to 3 and set the width of valor_in and valor.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 pet  input  1  host request; sampled only in REPOSO.
REQ-007 valor_in  input  W_VALOR  operand supplied by host with pet.
REQ-008 listo  output  1  high when a request can be accepted.
REQ-009 valor  output  W_VALOR  registered operand driven to the counting unit.
REQ-010 start  output  1  single-cycle launch pulse to the counting unit.
REQ-011 cuenta  input  4  result from the counting unit.
REQ-012 fin  input  1  completion flag from the counting unit.
REQ-013 resultado  output  4  captured result held for the host.
REQ-014 valido  output  1  resultado/error are valid.
REQ-015 error  output  1  the operation ended by timeout.
REQ-016 ack  input  1  host consumed resultado.

Function
REQ-017 The FSM SHALL have exactly four states: REPOSO, ARRANQUE, ESPERA, ENTREGA.
REQ-018 REPOSO: listo=1; pet=1 SHALL load valor<=valor_in and move to ARRANQUE on the same edge.
REQ-019 ARRANQUE: start=1 for exactly one cycle; the timeout counter clears to 0; the next state is ESPERA unconditionally.
REQ-020 ARRANQUE SHALL ignore fin, which may still be left over from a previous operation.
REQ-021 ESPERA, fin=1: resultado<=cuenta, error<=0, next state ENTREGA.
REQ-022 ESPERA, fin=0: the counter increments each cycle.
REQ-023 ESPERA timeout: when the counter equals TIMEOUT-1 and fin=0, resultado<=0, error<=1, next state ENTREGA.
REQ-024 If fin=1 in the timeout cycle, fin SHALL win and error stays 0.
REQ-025 ENTREGA: valido=1 and resultado/error are stable until ack=1; ack=1 moves to REPOSO on that edge.
REQ-026 pet outside REPOSO SHALL be ignored and not queued; pet together with ack in ENTREGA is not captured.
REQ-027 ack outside ENTREGA SHALL be ignored.
REQ-028 valor SHALL stay constant from ARRANQUE until the return to REPOSO.
REQ-029 Latency: request accepted at edge N -> start high in cycle N+1; fin seen at edge M -> valido high from cycle M+1.
REQ-030 The counter SHALL be ceil(log2(TIMEOUT)) bits wide and never wrap inside ESPERA.
REQ-031 listo, start and valido SHALL be decoded only from registered state (glitch-free, Moore).

Reset
REQ-032 reset_n low SHALL immediately force state=REPOSO, valor=0, resultado=0, error=0, counter=0, start=0, valido=0, listo=1.
REQ-033 Reset mid-operation (any state) SHALL abort without emitting start or valido; after release the block accepts pet normally.

Structure
REQ-034 State encodings and the TIMEOUT default SHALL live in shared package cuenta_pkg, reused by the counting unit.
REQ-035 The timeout counter SHALL be a sub-module temporizador (clear, enable, terminal-count output).
REQ-036 The block SHALL be one FSM plus datapath registers, with no other hierarchy.

Verification
REQ-037 Normal: pet=1, valor_in=3'b111; model raises fin with cuenta=4'b0011 after 5 cycles -> one start pulse; valido=1, resultado=0011, error=0 one cycle after fin.
REQ-038 Timeout: fin held 0 -> valido=1, error=1, resultado=0000 exactly TIMEOUT ESPERA cycles after ARRANQUE.
REQ-039 Race: fin=1 in the cycle the counter reaches TIMEOUT-1 -> error=0 and resultado=cuenta.
REQ-040 Back-pressure: ack held 0 for 10 cycles then pulsed -> valido held 10+ cycles with stable data; pet pulses during that time produce no extra start.
REQ-041 Stale fin: fin=1 during ARRANQUE, then 0 -> no capture; operation continues in ESPERA.
REQ-042 Reset: reset_n asserted mid-ESPERA -> all outputs at reset values in the same cycle; a new pet=1, valor_in=3'b010 completes normally.
